dma_arbiter: RTL

//  Shares the 18-bit Unibus memory port between NREQ DMA devices (rk_regs, future rl/tm) and the CPU.

---
 rtl/dma_arbiter_pkg.sv | 17 +
 rtl/dma_arbiter_rr_pick.sv | 25 ++
 rtl/dma_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dma_arbiter_pkg.sv
// Shared types and widths for the Unibus DMA arbiter: state encoding, bus widths
// and the latched transfer record.
package dma_arbiter_pkg;
    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int TCW = 7;
    localparam int BCW = 4;

    typedef enum logic [2:0] {
        IDLE, HOLD, ARB, MEMRD, ACK, MEMWR, NEXT, REL
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } xfer_t;
endpackage

// File: rtl/dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after 'last',
// wrapping modulo NREQ, so 'last' itself has the lowest priority.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] gnt
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    // Scan from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        valid = |req;
        gnt   = '0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) gnt = idx;
        end
    end
endmodule

// File: rtl/dma_arbiter.sv
// Shares the 18-bit Unibus memory port between NREQ DMA devices and the CPU.
// Round-robin grants, one speculative read (plus optional write) per grant.
module dma_arbiter import dma_arbiter_pkg::*; #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          dma_req,
    input  logic [NREQ-1:0][AW-1:0]  dma_addr,
    input  logic [NREQ-1:0][DW-1:0]  dma_data_out,
    input  logic [NREQ-1:0]          dma_rd,
    input  logic [NREQ-1:0]          dma_wr,
    output logic [NREQ-1:0]          dma_ack,
    output logic [DW-1:0]            dma_data_in,
    output logic [NREQ-1:0]          dma_nxm,
    output logic                     cpu_hold_req,
    input  logic                     cpu_hold_ack,
    output logic [AW-1:0]            mem_addr,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [DW-1:0]            mem_data_out,
    input  logic [DW-1:0]            mem_data_in,
    input  logic                     mem_done
);
    localparam int             IW   = $clog2(NREQ);
    localparam logic [TCW-1:0] TLIM = TCW'(TIMEOUT - 1);
    localparam logic [BCW-1:0] BMAX = BCW'(MAX_BURST);

    state_t          state, nstate;
    logic [IW-1:0]   gnt, rr_last, pick;
    logic            pick_vld;
    xfer_t           xfer;
    logic [DW-1:0]   rdata;
    logic            nxm;
    logic [BCW-1:0]  bcnt;
    logic [TCW-1:0]  tcnt;
    logic            tmo;

    // A read strobe alone means "read only", which is also the default, so it carries no information.
    logic rd_unused;
    assign rd_unused = |dma_rd;

    assign tmo = (tcnt >= TLIM);

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (dma_req),
        .last  (rr_last),
        .valid (pick_vld),
        .gnt   (pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (|dma_req) nstate = HOLD;
            HOLD:    if (cpu_hold_ack) nstate = ARB;
            ARB:     nstate = pick_vld ? MEMRD : REL;
            MEMRD:   if (mem_done || tmo) nstate = ACK;
            ACK:     nstate = (dma_wr[gnt] && !nxm) ? MEMWR : NEXT;
            MEMWR:   if (mem_done || tmo) nstate = NEXT;
            NEXT:    nstate = (bcnt < BMAX && |dma_req) ? ARB : REL;
            REL:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt     <= '0;
            rr_last <= IW'(NREQ - 1);
            xfer    <= '0;
            rdata   <= '0;
            nxm     <= 1'b0;
            bcnt    <= '0;
            tcnt    <= '0;
        end else begin
            case (state)
                ARB: if (pick_vld) begin
                    gnt     <= pick;
                    rr_last <= pick;
                    xfer    <= '{addr: dma_addr[pick], wdata: dma_data_out[pick]};
                    tcnt    <= '0;
                end
                MEMRD: begin
                    if (mem_done) begin
                        rdata <= mem_data_in;
                    end else if (tmo) begin
                        nxm   <= 1'b1;
                        rdata <= '0;
                    end
                    if (tcnt != '1) tcnt <= tcnt + TCW'(1);
                end
                ACK: begin
                    bcnt <= bcnt + BCW'(1);
                    tcnt <= '0;
                end
                MEMWR: if (tcnt != '1) tcnt <= tcnt + TCW'(1);
                NEXT: begin
                    nxm  <= 1'b0;
                    tcnt <= '0;
                end
                REL:     bcnt <= '0;
                default: ;
            endcase
        end
    end

    // Outputs depend on registered state only, so reset drops them immediately.
    always_comb begin
        dma_ack      = '0;
        dma_nxm      = '0;
        dma_data_in  = '0;
        cpu_hold_req = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        case (state)
            HOLD, ARB, NEXT: cpu_hold_req = 1'b1;
            MEMRD: begin
                cpu_hold_req = 1'b1;
                mem_rd       = 1'b1;
                mem_addr     = xfer.addr;
            end
            ACK: begin
                cpu_hold_req = 1'b1;
                dma_ack[gnt] = 1'b1;
                dma_nxm[gnt] = nxm;
                dma_data_in  = rdata;
            end
            MEMWR: begin
                cpu_hold_req = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = xfer.addr;
                mem_data_out = xfer.wdata;
            end
            default: ;
        endcase
    end
endmodule
